// File: rtl/seg_scan_ctrl_pkg.sv
// Shared display constants and types for the seven-segment scan controller
// and other users of the seg/an/dp bus.
package seg_scan_ctrl_pkg;

  localparam int unsigned SLOT_W = 2;
  localparam int unsigned NSLOTS = 4;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  typedef logic [SLOT_W-1:0] slot_t;

  localparam slot_t LAST_SLOT = slot_t'(NSLOTS - 1);

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [3:0]  blink;
  } shadow_t;

  // The display stays dark until the first load reaches a frame boundary.
  localparam shadow_t SHADOW_RST = '{
    digits: 16'h0000,
    dp:     4'h0,
    blank:  4'hF,
    blink:  4'h0
  };

  function automatic logic [3:0] anode_sel(input slot_t s);
    return ~(4'b0001 << s);
  endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Hex nibble to active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
module hex_to_7seg (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b1111111;
    unique case (hex)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Round-robin scan of the 4-digit common-anode display with dead time,
// blanking, blinking and frame-aligned double-buffered display data.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned FAST_DIV     = 4,
  parameter int unsigned DEAD         = 1,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic        MCLK,
  input  logic        reset,
  input  logic        fast,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank,
  input  logic [3:0]  blink,
  input  logic        load,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int unsigned DIV_MAX = (SCAN_DIV > FAST_DIV) ? SCAN_DIV : FAST_DIV;
  localparam int unsigned CW      = $clog2(DIV_MAX + 1);
  localparam int unsigned FW      = $clog2(BLINK_FRAMES + 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] div_last;
  slot_t         slot;
  logic          pending;
  logic          blink_phase;
  logic [FW-1:0] frame_cnt;
  shadow_t       sh;

  logic          terminal;
  logic          boundary;
  logic [3:0]    nibble;
  logic [6:0]    nibble_seg;
  logic          dark;
  logic [3:0]    an_next;
  logic [6:0]    seg_next;
  logic          dp_next;

  // ">=" rather than "==" so a mid-slot drop to the short divider ends the
  // slot on the next cycle instead of running the counter round a wrap.
  assign div_last = fast ? CW'(FAST_DIV - 1) : CW'(SCAN_DIV - 1);
  assign terminal = (cnt >= div_last);
  assign boundary = terminal && (slot == LAST_SLOT);

  always_ff @(posedge MCLK or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      slot <= '0;
    end else if (terminal) begin
      cnt  <= '0;
      slot <= slot + slot_t'(1);
    end else begin
      cnt  <= cnt + CW'(1);
    end
  end

  always_ff @(posedge MCLK or posedge reset) begin
    if (reset) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (boundary) begin
      if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt   <= frame_cnt + FW'(1);
      end
    end
  end

  // A load in the boundary cycle itself is consumed there, so pending
  // always clears on a boundary.
  always_ff @(posedge MCLK or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
      sh      <= SHADOW_RST;
    end else begin
      pending <= boundary ? 1'b0 : (pending | load);
      if (boundary && (pending || load)) begin
        sh.digits <= digits;
        sh.dp     <= dp_in;
        sh.blank  <= blank;
        sh.blink  <= blink;
      end
    end
  end

  assign nibble = sh.digits[{slot, 2'b00} +: 4];

  hex_to_7seg u_dec (
    .hex (nibble),
    .seg (nibble_seg)
  );

  assign dark = (cnt < CW'(DEAD)) || sh.blank[slot] || (sh.blink[slot] && blink_phase);

  always_comb begin
    an_next  = AN_OFF;
    seg_next = SEG_OFF;
    dp_next  = 1'b1;
    if (!dark) begin
      an_next  = anode_sel(slot);
      seg_next = nibble_seg;
      dp_next  = ~sh.dp[slot];
    end
  end

  always_ff @(posedge MCLK or posedge reset) begin
    if (reset) begin
      an         <= AN_OFF;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      an         <= an_next;
      seg        <= seg_next;
      dp         <= dp_next;
      frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a cycle-level behavioural model pushes
// the expected pin state each edge, a monitor pops and compares it.
module tb_seg_scan_ctrl;

  localparam int SCAN = 20;
  localparam int FASTD = 4;
  localparam int DEADC = 1;
  localparam int BF = 2;

  logic        MCLK = 1'b0;
  logic        reset = 1'b1;
  logic        fast = 1'b1;
  logic [15:0] digits = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank = '0;
  logic [3:0]  blink = '0;
  logic        load = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  seg_scan_ctrl #(
    .SCAN_DIV     (SCAN),
    .FAST_DIV     (FASTD),
    .DEAD         (DEADC),
    .BLINK_FRAMES (BF)
  ) dut (
    .MCLK       (MCLK),
    .reset      (reset),
    .fast       (fast),
    .digits     (digits),
    .dp_in      (dp_in),
    .blank      (blank),
    .blink      (blink),
    .load       (load),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 MCLK = ~MCLK;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } exp_t;

  exp_t q[$];

  // Character shapes, active low {g,f,e,d,c,b,a}.
  logic [6:0] shape [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Model: position inside the current slot, which slot, frames seen since
  // the last blink toggle, and the displayed (buffered) settings.
  int          m_pos, m_slot, m_frames;
  bit          m_phase, m_pend;
  logic [15:0] s_dig;
  logic [3:0]  s_dp, s_blank, s_blink;

  task automatic model_init();
    m_pos = 0; m_slot = 0; m_frames = 0; m_phase = 0; m_pend = 0;
    s_dig = 16'h0000; s_dp = 4'h0; s_blank = 4'hF; s_blink = 4'h0;
  endtask

  initial model_init();

  always @(posedge MCLK) begin
    exp_t e;
    int   div;
    bit   slot_end, frame_end;
    if (reset) begin
      model_init();
      q.delete();
    end else begin
      div = fast ? FASTD : SCAN;
      if (m_pos < DEADC || s_blank[m_slot] || (s_blink[m_slot] && m_phase)) begin
        e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
      end else begin
        e.an  = 4'hF;
        e.an[m_slot] = 1'b0;
        e.seg = shape[s_dig[m_slot*4 +: 4]];
        e.dp  = ~s_dp[m_slot];
      end
      slot_end  = (m_pos + 1 >= div);
      frame_end = slot_end && (m_slot == 3);
      e.fd = frame_end;
      q.push_back(e);
      if (frame_end) begin
        if (m_pend || load) begin
          s_dig = digits; s_dp = dp_in; s_blank = blank; s_blink = blink;
        end
        m_pend = 0;
        m_frames++;
        if (m_frames == BF) begin
          m_frames = 0;
          m_phase = !m_phase;
        end
      end else if (load) begin
        m_pend = 1;
      end
      if (slot_end) begin
        m_pos = 0;
        m_slot = (m_slot + 1) % 4;
      end else begin
        m_pos++;
      end
    end
  end

  always @(posedge MCLK) begin
    exp_t e;
    #1;
    cyc++;
    if (!reset) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty cyc=%0d got an=%b required an=<expected entry>", cyc, an);
      end else begin
        e = q.pop_front();
        if (an !== e.an || seg !== e.seg || dp !== e.dp || frame_done !== e.fd ||
            $countones(~an) > 1) begin
          errors++;
          if (errors <= 40)
            $display("FAIL scan cyc=%0d got an=%b seg=%b dp=%b fd=%b required an=%b seg=%b dp=%b fd=%b",
                     cyc, an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge MCLK);
  endtask

  task automatic pulse_load();
    load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  task automatic check_dark(input string name);
    checks++;
    if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL %s got an=%b seg=%b dp=%b fd=%b required an=1111 seg=1111111 dp=1 fd=0",
               name, an, seg, dp, frame_done);
    end
  endtask

  initial begin
    bit lit;
    step(3);
    check_dark("reset_state");
    reset = 1'b0;

    // Load with nothing else driven: still dark through the first frame.
    pulse_load();
    step(40);

    digits = 16'h1234; blank = 4'h0;
    pulse_load();
    step(48);

    // Live change without load must not reach the display.
    digits = 16'h0000;
    step(24);
    step(6);
    pulse_load();
    step(40);

    digits = 16'h1234; blink = 4'b0001;
    pulse_load();
    step(16 * 9);

    blink = 4'h0; dp_in = 4'b0100; blank = 4'b1000; digits = 16'hABCD;
    pulse_load();
    load = 1'b1; step(3); load = 1'b0;
    step(48);

    // Slow mode, then drop to fast mid-slot.
    blank = 4'h0; digits = 16'hE5F9; dp_in = 4'b1010;
    fast = 1'b0;
    pulse_load();
    step(2 * 80 + 11);
    fast = 1'b1;
    step(40);

    // Asynchronous reset while a digit is lit.
    lit = 0;
    for (int i = 0; i < 200 && !lit; i++) begin
      step(1);
      if (an != 4'hF) lit = 1;
    end
    checks++;
    if (!lit) begin
      errors++;
      $display("FAIL lit_timeout got an=%b required a lit anode within 200 cycles", an);
    end
    reset = 1'b1;
    #1;
    check_dark("async_reset");
    step(3);
    check_dark("reset_hold");
    reset = 1'b0;
    step(40);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      digits = 16'($urandom);
      dp_in  = 4'($urandom);
      blank  = 4'($urandom) & 4'($urandom);
      blink  = 4'($urandom);
      load   = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 49) == 0) fast = ~fast;
      step(1);
    end
    load = 1'b0;
    step(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexing scheduler for the board's 4-digit common-anode seven-segment display.
- Shares the single seg/dp bus between four digit slots in a fixed round-robin, with per-slot dead time, blanking and blinking.
- Double-buffered display data is swapped only at frame boundaries, so time/alarm values from the clock logic never tear.
- Sits between the alarm-clock datapath and the top-level seg/an/dp pins; the fast input (driven by sw[1]) shortens the scan for simulation.

Parameters:
- SCAN_DIV, 50000, MCLK cycles per digit slot in normal mode.
- FAST_DIV, 4, MCLK cycles per digit slot when fast=1; must satisfy FAST_DIV > DEAD.
- DEAD, 1, cycles at the start of each slot with all anodes off (anti-ghosting).
- BLINK_FRAMES, 64, full frames per blink-phase toggle.

Ports:
- MCLK  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- fast  in  1  1 = use FAST_DIV, 0 = use SCAN_DIV.
- digits  in  16  four hex nibbles; [3:0] is slot 0 (rightmost, an[0]).
- dp_in  in  4  decimal point per slot, 1 = lit.
- blank  in  4  per-slot blank, 1 = dark.
- blink  in  4  per-slot blink enable.
- load  in  1  one-cycle request to capture digits/dp_in/blank/blink at the next frame boundary.
- an  out  4  anode enables, active low.
- seg  out  7  segments, active low; seg[0]=a … seg[6]=g.
- dp  out  1  decimal point, active low.
- frame_done  out  1  one-cycle pulse at each frame boundary.

Behaviour:
- Reset (async): an=4'b1111, seg=7'h7F, dp=1, frame_done=0; prescaler=0, slot=0, pending=0, blink_phase=0, frame counter=0.
- Reset values of the shadow registers: digits=0, dp=0, blank=4'b1111 (display dark until the first load), blink=0.
- Prescaler: counts 0..DIV-1, where DIV = fast ? FAST_DIV : SCAN_DIV.
  - Terminal condition is count >= DIV-1. A mid-slot switch to fast therefore ends the slot on the next cycle, never after a wrap.
  - On terminal: count←0 and slot←slot+1, wrapping 3→0.
- Frame boundary = terminal while slot==3.
  - frame_done=1 for exactly that cycle, registered.
  - Frame counter increments. On reaching BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
- Load handshake:
  - load sets pending.
  - At a frame boundary with pending=1 or load=1, shadows capture the live inputs of that cycle and pending clears.
  - load during a non-boundary cycle is never lost. Repeated loads before a boundary collapse into one capture of the boundary-cycle values.
- Outputs are registered, with 1-cycle latency from internal slot/count state:
  - count < DEAD: an=1111, seg=7F, dp=1.
  - Slot blanked (shadow blank[i]=1, or shadow blink[i]=1 and blink_phase=1): an=1111, seg=7F, dp=1.
  - Otherwise: an = ~(1<<i), seg = decode(nibble i), dp = ~shadow_dp[i].
- Decode (active low, {g,f,e,d,c,b,a}): 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001, 5→0010010, 6→0000010, 7→1111000, 8→0000000, 9→0010000, A→0001000, b→0000011, C→1000110, d→0100001, E→0000110, F→0001110.
- At most one anode is ever low.
- Reset mid-slot: all outputs go dark immediately. Scanning restarts at slot 0 after release and a pending load is discarded.

Decomposition:
- Shared constants go in the existing mux_sel.vh-style header: SEG_OFF=7'h7F, AN_OFF=4'hF, slot index width (2).
- One combinational sub-module, hex_to_7seg: 4-bit in, 7-bit active-low out. Also reusable by other display users.
- Everything else (prescaler, slot counter, shadow regs, blink counter, output regs) lives in seg_scan_ctrl.

Test Plan:
- Reset, then load with no other stimulus, fast=1 → an=1111, seg=7F for the whole first frame (blank=1111 in shadow). After reset release, frame_done pulses every 16 cycles.
- fast=1, digits=16'h1234, blank=0, load pulsed once → from the next frame, per 4-cycle slot: 1 dead cycle, then an=1110/seg=0011001, an=1101/seg=0110000, an=1011/seg=0100100, an=0111/seg=1111001.
- Change digits to 16'h0000 mid-frame without load → display unchanged. Pulse load mid-frame → new value appears only in the slot-0 window after the next frame_done.
- blink=4'b0001, BLINK_FRAMES=2 → slot 0 alternates lit/dark every 2 frames; slots 1-3 stay lit; an[0] never low while dark.
- dp_in=4'b0100, blank=4'b1000 → dp=0 only during the slot-2 window; an[3] never asserted.
- Switch fast 0→1 while count=1000 → slot advances the next cycle. Assert reset mid-slot → an=1111 asynchronously, same cycle.
